clasificador_rechazo: RTL and testbench
=======================================

// Module: clasificador_rechazo
// PURPOSE
//  Downstream stage of the inspection Moore FSM; consumes its 2-bit verdict E.
//  Counts approved/rejected products and drives the reject diverter actuator
//  after the conveyor travel delay. Raises a sticky alarm on a run of consecutive
//  rejects. Flags a sticky error if rejects arrive faster than the diverter can serve.
// PARAMETERS
//  DELAY     4  cycles from reject sample to diverter rise (>=1)
//  PULSE_LEN 3  cycles diverter held high (>=1)
//  ALARM_TH  3  consecutive rejects that set alarm (>=1)
//  CNT_W     8  width of cnt_ok / cnt_rej
// PORTS
//  clk          in   1      system clock, rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  E            in   2      verdict: 00 none, 01 advance, 10 rejected, 11 approved
//  clr          in   1      sync clear of counters, consecutive count, alarm, err_ovf
//  diverter     out  1      actuator push; registered, = (state==PUSH)
//  cnt_ok       out  CNT_W  approved count
//  cnt_rej      out  CNT_W  rejected count
//  alarm        out  1      sticky: ALARM_TH consecutive rejects seen
//  err_ovf      out  1      sticky: reject arrived with pending already set
//  busy         out  1      state!=IDLE or pending
//  sorter_state out  2      IDLE 00, WAIT 01, PUSH 10, GUARD 11
// BEHAVIOUR
//  - reset_n=0: state IDLE, tmr/pending/consec 0, all outputs 0, asynchronously.
//  - Events are decoded from E in the sampling cycle: rej = (E==2'b10), ok = (E==2'b11).
//    00/01 are ignored. Each cycle E==10 is a separate reject (same for 11).
//  - FSM, 1 transition per edge:
//    IDLE : rej -> WAIT, tmr=DELAY-1.
//    WAIT : tmr==0 -> PUSH, tmr=PULSE_LEN-1; else tmr--.
//    PUSH : tmr==0 -> GUARD; else tmr--.
//    GUARD: 1 cycle, diverter low; pending -> WAIT, tmr=DELAY-1, pending=0;
//           else IDLE.
//  - Latency: reject sampled on edge k -> diverter 1 after edges k+DELAY ..
//    k+DELAY+PULSE_LEN-1 -> 0 after edge k+DELAY+PULSE_LEN.
//  - Reject sampled while state!=IDLE: pending==0 -> pending=1.
//    pending==1 -> err_ovf=1; reject still counted; no extra pulse.
//  - Reject on the GUARD-exit edge with pending=1: err_ovf=1; the pending
//    reject is served.
//  - A queued reject starts its DELAY when GUARD exits, not at sample time.
//  - Counters: ok -> cnt_ok+1; rej -> cnt_rej+1.
//  - consec: rej -> consec+1, saturating at ALARM_TH; ok -> 0.
//  - alarm is set on the edge consec reaches ALARM_TH; it holds until clr or reset.
//  - clr: counters, consec, alarm and err_ovf go to 0. An event in the same cycle
//    is not counted (clr wins). A reject in that cycle still schedules or queues
//    the diverter. clr never aborts the FSM or clears pending.
// CONFIGURATION
//  CLASIF_SATURATE_EN defined: cnt_ok/cnt_rej saturate at 2**CNT_W-1.
//  Not defined: both counters wrap to 0 modulo 2**CNT_W.
//  All other behaviour is identical in both builds.
// TESTING (DELAY=4, PULSE_LEN=3, ALARM_TH=3 unless noted)
//  1 E=10 for 1 cycle on edge 10 -> diverter=1 after edges 14,15,16 and 0 after 17;
//    cnt_rej=1; sorter_state 01,10,11,00.
//  2 E=10 on edges 10 and 12 -> 2nd goes pending; pulses 14-16 and 22-24; err_ovf=0.
//    A 3rd reject on edge 13 -> err_ovf=1, cnt_rej=3.
//  3 Three E=10 separated by E=00 -> alarm=1 after the 3rd edge.
//    Sequence 10,11,10,10 -> alarm stays 0.
//  4 reset_n=0 mid-PUSH -> diverter, busy and sorter_state 0 without a clock edge;
//    after release, an idle bench gives no pulse.
//  5 CNT_W=4, 16 approvals -> cnt_ok=15 with CLASIF_SATURATE_EN, 0 without.
//  6 clr=1 together with E=10 on edge 10 -> cnt_rej=0 and alarm=0;
//    diverter still high after edges 14-16.

Source files
------------

// File: rtl/clasificador_rechazo.sv
// clasificador_rechazo
//   Downstream stage of the inspection FSM. Consumes the 2-bit verdict E,
//   counts approved/rejected products and fires the reject diverter once the
//   product has travelled the conveyor delay. It raises a sticky alarm on a
//   run of consecutive rejects and a sticky error when rejects arrive faster
//   than the diverter can serve them (one in service plus one queued).
//
//   Build option: define CLASIF_SATURATE_EN to make cnt_ok/cnt_rej saturate
//   at 2**CNT_W-1. Without it both counters wrap modulo 2**CNT_W.
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   E            in   verdict: 00 none, 01 advance, 10 rejected, 11 approved
//   clr          in   sync clear of counters, consec run, alarm, err_ovf
//   diverter     out  actuator push (registered, high while in PUSH)
//   cnt_ok       out  approved count
//   cnt_rej      out  rejected count
//   alarm        out  sticky: ALARM_TH consecutive rejects seen
//   err_ovf      out  sticky: reject arrived while one was already queued
//   busy         out  sorter not idle or a reject is queued
//   sorter_state out  IDLE 00, WAIT 01, PUSH 10, GUARD 11
module clasificador_rechazo #(
  parameter int DELAY     = 4,
  parameter int PULSE_LEN = 3,
  parameter int ALARM_TH  = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       E,
  input  logic             clr,
  output logic             diverter,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_rej,
  output logic             alarm,
  output logic             err_ovf,
  output logic             busy,
  output logic [1:0]       sorter_state
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_WAIT  = 2'b01;
  localparam logic [1:0] S_PUSH  = 2'b10;
  localparam logic [1:0] S_GUARD = 2'b11;

  localparam int TMAX = (DELAY > PULSE_LEN) ? DELAY : PULSE_LEN;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(ALARM_TH + 1);

  localparam logic [TW-1:0] T_DLY = TW'(DELAY - 1);
  localparam logic [TW-1:0] T_PLS = TW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] C_TH  = CW'(ALARM_TH);

  logic [1:0]    state, state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic          pending, pending_nxt;
  logic          ovf;
  logic [CW-1:0] consec, consec_nxt;
  logic          rej, ok;

  assign rej = (E == 2'b10);
  assign ok  = (E == 2'b11);

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef CLASIF_SATURATE_EN
    return (&v) ? v : v + 1'b1;
`else
    return v + 1'b1;
`endif
  endfunction

  // Sorter FSM plus single-entry reject queue.
  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr;
    pending_nxt = pending;
    ovf         = 1'b0;
    case (state)
      S_IDLE: begin
        if (rej) begin
          state_nxt = S_WAIT;
          tmr_nxt   = T_DLY;
        end
      end
      S_WAIT: begin
        if (tmr == '0) begin
          state_nxt = S_PUSH;
          tmr_nxt   = T_PLS;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_PUSH: begin
        if (tmr == '0) state_nxt = S_GUARD;
        else           tmr_nxt   = tmr - 1'b1;
      end
      default: begin
        // GUARD exit: serve the queued reject first. A fresh reject on this
        // edge with the queue empty starts directly, which times it exactly
        // as if it had been queued and released on this same edge. With the
        // queue full the fresh reject is dropped and flagged.
        if (pending) begin
          state_nxt   = S_WAIT;
          tmr_nxt     = T_DLY;
          pending_nxt = 1'b0;
          ovf         = rej;
        end else if (rej) begin
          state_nxt = S_WAIT;
          tmr_nxt   = T_DLY;
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
    if (rej && (state == S_WAIT || state == S_PUSH)) begin
      if (pending) ovf         = 1'b1;
      else         pending_nxt = 1'b1;
    end
  end

  // Consecutive-reject run, saturating at the alarm threshold.
  always_comb begin
    consec_nxt = consec;
    if (rej) begin
      if (consec != C_TH) consec_nxt = consec + 1'b1;
    end else if (ok) begin
      consec_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      tmr      <= '0;
      pending  <= 1'b0;
      diverter <= 1'b0;
    end else begin
      state    <= state_nxt;
      tmr      <= tmr_nxt;
      pending  <= pending_nxt;
      diverter <= (state_nxt == S_PUSH);
    end
  end

  // Statistics; clr wins over any event in the same cycle but never touches
  // the sorter itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_ok  <= '0;
      cnt_rej <= '0;
      consec  <= '0;
      alarm   <= 1'b0;
      err_ovf <= 1'b0;
    end else if (clr) begin
      cnt_ok  <= '0;
      cnt_rej <= '0;
      consec  <= '0;
      alarm   <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      if (ok)  cnt_ok  <= bump(cnt_ok);
      if (rej) cnt_rej <= bump(cnt_rej);
      consec <= consec_nxt;
      if (consec_nxt == C_TH) alarm   <= 1'b1;
      if (ovf)                err_ovf <= 1'b1;
    end
  end

  assign busy         = (state != S_IDLE) || pending;
  assign sorter_state = state;

endmodule

// File: tb/tb_clasificador_rechazo.sv
module tb_clasificador_rechazo;
  localparam int D = 4, P = 3, TH = 3, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    E;
  logic          clr;
  logic          diverter, alarm, err_ovf, busy;
  logic [CW-1:0] cnt_ok, cnt_rej;
  logic [1:0]    sorter_state;

  int total = 0;
  int bad   = 0;

  clasificador_rechazo #(.DELAY(D), .PULSE_LEN(P), .ALARM_TH(TH), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .E(E), .clr(clr), .diverter(diverter),
    .cnt_ok(cnt_ok), .cnt_rej(cnt_rej), .alarm(alarm), .err_ovf(err_ovf),
    .busy(busy), .sorter_state(sorter_state)
  );

  always #5 clk = ~clk;

  // Reference model: time-based. A served reject that starts at edge s is in
  // WAIT for edges s..s+D-1, pushes for s+D..s+D+P-1, guards at s+D+P and
  // leaves guard on edge s+D+P+1.
  int cyc, s, m_ok, m_rej, consec;
  bit act, pend, m_alarm, m_err;

  function automatic int inc(input int v);
`ifdef CLASIF_SATURATE_EN
    return (v == CMAX) ? v : v + 1;
`else
    return (v + 1) % (CMAX + 1);
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit rej, ok, ovf;
    if (!reset_n) begin
      cyc = 0; act = 0; s = 0; pend = 0;
      m_ok = 0; m_rej = 0; consec = 0; m_alarm = 0; m_err = 0;
    end else begin
      cyc++;
      rej = (E == 2'b10);
      ok  = (E == 2'b11);
      ovf = 0;
      if (act && cyc == s + D + P + 1) begin
        if (pend) begin s = cyc; pend = 0; ovf = rej; end
        else if (rej) s = cyc;
        else act = 0;
      end else if (act) begin
        if (rej) begin if (pend) ovf = 1; else pend = 1; end
      end else if (rej) begin
        act = 1; s = cyc;
      end
      if (clr) begin
        m_ok = 0; m_rej = 0; consec = 0; m_alarm = 0; m_err = 0;
      end else begin
        if (ok)  m_ok  = inc(m_ok);
        if (rej) m_rej = inc(m_rej);
        if (rej) consec = (consec < TH) ? consec + 1 : TH;
        else if (ok) consec = 0;
        if (consec == TH) m_alarm = 1;
        if (ovf) m_err = 1;
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    int est;
    est = !act ? 0 : (cyc < s + D) ? 1 : (cyc < s + D + P) ? 2 : 3;
    chk("m_div",   diverter, (act && cyc >= s + D && cyc <= s + D + P - 1) ? 1 : 0);
    chk("m_state", sorter_state, est);
    chk("m_busy",  busy, (act || pend) ? 1 : 0);
    chk("m_ok",    cnt_ok, m_ok);
    chk("m_rej",   cnt_rej, m_rej);
    chk("m_alarm", alarm, m_alarm);
    chk("m_err",   err_ovf, m_err);
  end

  task automatic tick(input logic [1:0] e, input logic c);
    @(negedge clk);
    E = e; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(2'b00, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; E = 2'b00; clr = 1'b0;
    #12;
    chk("rst_div", diverter, 0);
    chk("rst_state", sorter_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", {cnt_ok, cnt_rej}, 0);
    chk("rst_flags", {alarm, err_ovf}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // Single reject: WAIT x3, PUSH x3, GUARD, IDLE.
    tick(2'b10, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick(2'b00, 1'b0);
      chk("t1_div", diverter, (i >= 4 && i <= 6) ? 1 : 0);
      chk("t1_state", sorter_state, (i <= 3) ? 1 : (i <= 6) ? 2 : (i == 7) ? 3 : 0);
    end
    chk("t1_rej", cnt_rej, 1);

    // Second reject queued, served after guard exit.
    tick(2'b00, 1'b1);
    idle(2);
    tick(2'b10, 1'b0);
    tick(2'b00, 1'b0);
    tick(2'b10, 1'b0);
    chk("t2_busy", busy, 1);
    for (int i = 3; i <= 16; i++) begin
      tick(2'b00, 1'b0);
      chk("t2_div", diverter, ((i >= 4 && i <= 6) || (i >= 12 && i <= 14)) ? 1 : 0);
    end
    chk("t2_err0", err_ovf, 0);
    idle(4);
    tick(2'b00, 1'b1);
    tick(2'b10, 1'b0);
    tick(2'b00, 1'b0);
    tick(2'b10, 1'b0);
    tick(2'b10, 1'b0);
    chk("t2_err1", err_ovf, 1);
    chk("t2_rej3", cnt_rej, 3);
    idle(20);

    // Alarm on three separated rejects; broken run stays quiet.
    tick(2'b00, 1'b1);
    tick(2'b10, 1'b0); tick(2'b00, 1'b0);
    tick(2'b10, 1'b0); tick(2'b00, 1'b0);
    chk("t3_alarm0", alarm, 0);
    tick(2'b10, 1'b0);
    chk("t3_alarm1", alarm, 1);
    idle(20);
    tick(2'b00, 1'b1);
    tick(2'b10, 1'b0); tick(2'b11, 1'b0); tick(2'b10, 1'b0); tick(2'b10, 1'b0);
    chk("t3_alarm_brk", alarm, 0);
    idle(20);

    // Asynchronous reset in the middle of a push.
    tick(2'b10, 1'b0);
    idle(4);
    chk("t4_inpush", diverter, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t4_div", diverter, 0);
    chk("t4_busy", busy, 0);
    chk("t4_state", sorter_state, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(2'b00, 1'b0);
      chk("t4_quiet", diverter, 0);
    end

    // 16 approvals on a 4-bit counter.
    tick(2'b00, 1'b1);
    for (int i = 0; i < 16; i++) tick(2'b11, 1'b0);
`ifdef CLASIF_SATURATE_EN
    chk("t5_cnt", cnt_ok, 15);
`else
    chk("t5_cnt", cnt_ok, 0);
`endif

    // clr with a reject: not counted, diverter still fires.
    tick(2'b10, 1'b0); tick(2'b10, 1'b0); tick(2'b10, 1'b0);
    idle(20);
    tick(2'b10, 1'b1);
    chk("t6_rej", cnt_rej, 0);
    chk("t6_alarm", alarm, 0);
    for (int i = 1; i <= 7; i++) begin
      tick(2'b00, 1'b0);
      chk("t6_div", diverter, (i >= 4 && i <= 6) ? 1 : 0);
    end

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [1:0] e;
      r = $urandom_range(0, 9);
      e = (r < 3) ? 2'b10 : (r < 6) ? 2'b11 : (r < 8) ? 2'b00 : 2'b01;
      tick(e, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end
    idle(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
